// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage with valid/ready on both sides.
// Most ops finish in one cycle; SLL uses a one-bit-per-cycle serial shifter.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0010;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shreg_next;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             start_shift;
    logic             shift_last;

    function automatic logic [WIDTH-1:0] alu_calc(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[SHW-1:0];
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_ADD:  r = a + b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    assign in_ready    = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign shamt       = B[SHW-1:0];
    // SLL by zero takes the single-cycle path; only n>0 needs the serial shifter.
    assign start_shift = (ALU_op == OP_SLL) && (shamt != '0);
    assign shreg_next  = shreg << 1;
    assign shift_last  = (cnt == SHW'(1));
    assign alu_res     = alu_calc(ALU_op, A, B);

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = start_shift ? SHIFT : DONE;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                SHIFT:   if (shift_last) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            zero   <= 1'b0;
            shreg  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            if (accept && start_shift) begin
                shreg <= A;
                cnt   <= shamt;
            end else if (accept) begin
                result <= alu_res;
                zero   <= (alu_res == '0);
            end else if (state == SHIFT) begin
                shreg <= shreg_next;
                cnt   <= cnt - SHW'(1);
                if (shift_last) begin
                    result <= shreg_next;
                    zero   <= (shreg_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed spec cases plus a randomized
// stream scored against a plain-arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ALU_op = 4'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_op(ALU_op), .A(A), .B(B), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        longint unsigned p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'b1000: return a - b;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            4'b0001: begin
                p = 64'(a) * (64'd1 << b[4:0]);
                return p[31:0];
            end
            4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; ALU_op = 4'b0000; A = 32'd5; B = 32'd5;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0) begin
                bad++;
                $display("FAIL reset[%0d]: got rdy=%b ov=%b res=%h z=%b want 0 0 0 0",
                         i, in_ready, out_valid, result, zero);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_idle_ready: got %b want 1", in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_no_accept: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_single_cycle();
        logic [3:0]  ops [6] = '{4'b0000, 4'b1000, 4'b1000, 4'b0111, 4'b0110, 4'b0100};
        logic [31:0] as  [6] = '{32'd5, 32'd7, 32'd0, 32'hF0F0, 32'hF0F0, 32'hF0F0};
        logic [31:0] bs  [6] = '{32'd7, 32'd7, 32'd1, 32'hFF00, 32'hFF00, 32'hFF00};
        logic [31:0] want[6] = '{32'd12, 32'd0, 32'hFFFFFFFF, 32'hF000, 32'hFFF0, 32'h0FF0};
        logic [3:0]  op;
        logic [31:0] a, b, exp;
        out_ready = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i < 6) begin
                op = ops[i]; a = as[i]; b = bs[i]; exp = want[i];
            end else begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'b0001) op = 4'b0000;
                a = $urandom; b = $urandom;
                if ($urandom_range(0, 3) == 0) b = a;
                exp = ref_alu(op, a, b);
            end
            in_valid = 1'b1; ALU_op = op; A = a; B = b;
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
            end
            step();
            total++;
            if (out_valid !== 1'b1 || result !== exp || zero !== (exp == 32'd0)) begin
                bad++;
                $display("FAIL b2b_result[%0d] op=%b: got ov=%b res=%h z=%b want 1 %h %b",
                         i, op, out_valid, result, zero, exp, exp == 32'd0);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_slt_unknown();
        logic [3:0]  ops [4] = '{4'b0010, 4'b0010, 4'b0011, 4'b0010};
        logic [31:0] as  [4] = '{32'hFFFFFFFF, 32'd1, 32'd2, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd1, 32'hFFFFFFFF, 32'd3, 32'd1};
        logic [31:0] want[4] = '{32'd1, 32'd0, 32'd5, 32'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; ALU_op = ops[i]; A = as[i]; B = bs[i];
            step();
            total++;
            if (out_valid !== 1'b1 || result !== want[i] || zero !== (want[i] == 32'd0)) begin
                bad++;
                $display("FAIL slt_unknown[%0d]: got ov=%b res=%h z=%b want 1 %h",
                         i, out_valid, result, zero, want[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_sll();
        logic [31:0] as  [3] = '{32'd1, 32'd1, 32'hDEADBEEF};
        logic [31:0] bs  [3] = '{32'd31, 32'h25, 32'd0};
        logic [31:0] want[3] = '{32'h80000000, 32'h20, 32'hDEADBEEF};
        logic [31:0] a, b, exp, held;
        int n, lat, rdy_bad;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                a = as[i]; b = bs[i]; exp = want[i];
            end else begin
                a = $urandom; b = $urandom; exp = ref_alu(4'b0001, a, b);
            end
            n = int'(b[4:0]);
            out_ready = 1'b0; in_valid = 1'b1; ALU_op = 4'b0001; A = a; B = b;
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL sll_ready[%0d]: got %b want 1", i, in_ready);
            end
            step();
            // Garbage request held during the shift must neither be accepted nor disturb it.
            ALU_op = 4'($urandom); A = $urandom; B = $urandom;
            #1;
            lat = 1; rdy_bad = 0;
            while (out_valid !== 1'b1 && lat < 100) begin
                if (in_ready !== 1'b0) rdy_bad++;
                step();
                lat++;
            end
            total++;
            if (lat != n + 1) begin
                bad++; $display("FAIL sll_latency[%0d]: got %0d want %0d", i, lat, n + 1);
            end
            total++;
            if (result !== exp || zero !== (exp == 32'd0)) begin
                bad++; $display("FAIL sll_result[%0d]: got %h z=%b want %h", i, result, zero, exp);
            end
            total++;
            if (rdy_bad != 0) begin
                bad++; $display("FAIL sll_shift_ready[%0d]: in_ready high %0d times want 0", i, rdy_bad);
            end
            total++;
            if (in_ready !== 1'b0) begin
                bad++; $display("FAIL sll_done_blocked[%0d]: in_ready got %b want 0", i, in_ready);
            end
            held = result;
            step();
            total++;
            if (out_valid !== 1'b1 || result !== held) begin
                bad++; $display("FAIL sll_hold[%0d]: got ov=%b res=%h want 1 %h", i, out_valid, result, held);
            end
            in_valid = 1'b0; out_ready = 1'b1;
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL sll_consume[%0d]: out_valid got %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a1, b1, exp1, a2;
        a1 = $urandom; b1 = $urandom; exp1 = a1 + b1; a2 = $urandom;
        out_ready = 1'b0; in_valid = 1'b1; ALU_op = 4'b0000; A = a1; B = b1;
        step();
        ALU_op = 4'b1000; A = a2; B = a2;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || result !== exp1 || zero !== (exp1 == 32'd0) || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got ov=%b res=%h z=%b rdy=%b want 1 %h %b 0",
                         i, out_valid, result, zero, in_ready, exp1, exp1 == 32'd0);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_release: got rdy=%b ov=%b want 1 1", in_ready, out_valid);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
            bad++; $display("FAIL bp_handoff: got ov=%b res=%h z=%b want 1 0 1", out_valid, result, zero);
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_sll();
        int seen;
        out_ready = 1'b1; in_valid = 1'b1; ALU_op = 4'b0001; A = $urandom | 32'd1; B = 32'd20;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_state: got ov=%b res=%h z=%b rdy=%b want 0 0 0 1",
                     out_valid, result, zero, in_ready);
        end
        seen = 0;
        repeat (25) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL midrst_quiet: out_valid high %0d cycles want 0", seen);
        end
        in_valid = 1'b1; ALU_op = 4'b0000; A = 32'd1; B = 32'd1;
        step();
        total++;
        if (out_valid !== 1'b1 || result !== 32'd2 || zero !== 1'b0) begin
            bad++; $display("FAIL midrst_add: got ov=%b res=%h want 1 00000002", out_valid, result);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random_stream();
        logic [31:0] q[$];
        logic        pend, ov, hs, acc;
        logic [3:0]  op;
        logic [31:0] a, b, exp;
        pend = 1'b0; op = '0; a = '0; b = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                op = 4'($urandom_range(0, 15));
                a = $urandom;
                b = (op == 4'b0001) ? 32'($urandom_range(0, 6)) : $urandom;
            end
            in_valid = pend; ALU_op = op; A = a; B = b;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            ov = out_valid; hs = out_valid && out_ready; acc = pend && in_ready;
            if (hs) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL stream_spurious[%0d]: result %h with nothing pending", cyc, result);
                end else begin
                    exp = q.pop_front();
                    if (result !== exp || zero !== (exp == 32'd0)) begin
                        bad++; $display("FAIL stream_result[%0d]: got %h z=%b want %h", cyc, result, zero, exp);
                    end
                end
            end
            if (acc) begin
                q.push_back(ref_alu(op, a, b));
                pend = 1'b0;
            end
            step();
            if (ov && !hs) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++; $display("FAIL stream_drop[%0d]: out_valid got %b want 1", cyc, out_valid);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() > 0; k++) begin
            #1;
            if (out_valid === 1'b1) begin
                exp = q.pop_front();
                total++;
                if (result !== exp) begin
                    bad++; $display("FAIL stream_drain: got %h want %h", result, exp);
                end
            end
            step();
        end
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL stream_lost: %0d results outstanding want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_slt_unknown();
        test_sll();
        test_backpressure();
        test_reset_mid_sll();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
